// File: rtl/bitwise_reduce_acc_pkg.sv
// Shared definitions for the bitwise packet reducer: op codes, FSM states and op decode.
package bitwise_reduce_acc_pkg;

  localparam int unsigned OP_W = 3;

  localparam logic [OP_W-1:0] OP_AND     = 3'd0;
  localparam logic [OP_W-1:0] OP_OR      = 3'd1;
  localparam logic [OP_W-1:0] OP_XOR     = 3'd2;
  localparam logic [OP_W-1:0] OP_NAND    = 3'd3;
  localparam logic [OP_W-1:0] OP_NOR     = 3'd4;
  localparam logic [OP_W-1:0] OP_XNOR    = 3'd5;
  localparam logic [OP_W-1:0] OP_RSVD_LO = 3'd6;

  localparam logic [1:0] BASE_AND = 2'd0;
  localparam logic [1:0] BASE_OR  = 2'd1;
  localparam logic [1:0] BASE_XOR = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic [1:0] base;
    logic       inv;
    logic       rsvd;
  } op_dec_t;

  // Split an op code into the fold operation and a final-result inversion.
  function automatic op_dec_t op_decode(input logic [OP_W-1:0] op);
    op_dec_t d;
    d = '{base: BASE_AND, inv: 1'b0, rsvd: 1'b0};
    unique case (op)
      OP_AND:  d.base = BASE_AND;
      OP_OR:   d.base = BASE_OR;
      OP_XOR:  d.base = BASE_XOR;
      OP_NAND: d = '{base: BASE_AND, inv: 1'b1, rsvd: 1'b0};
      OP_NOR:  d = '{base: BASE_OR,  inv: 1'b1, rsvd: 1'b0};
      OP_XNOR: d = '{base: BASE_XOR, inv: 1'b1, rsvd: 1'b0};
      default: d.rsvd = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/bitwise_op_core.sv
// Combinational two-operand AND/OR/XOR selector used for the per-beat fold.
module bitwise_op_core
  import bitwise_reduce_acc_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y_c
);

  always_comb begin
    y_c = a & b;
    unique case (sel)
      BASE_OR:  y_c = a | b;
      BASE_XOR: y_c = a ^ b;
      default:  y_c = a & b;
    endcase
  end

endmodule

// File: rtl/bitwise_reduce_acc.sv
// Folds a packet of WIDTH-bit words with a selectable bitwise op; valid/ready on both sides.
module bitwise_reduce_acc
  import bitwise_reduce_acc_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned MAX_LEN = 16,
  localparam int unsigned CNT_W  = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       op,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_err
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
  logic [2:0]         op_q, op_d;
  logic               out_valid_d;
  logic [WIDTH-1:0]   out_data_d;
  logic [CNT_W-1:0]   out_count_d;
  logic               out_err_d;

  logic               accept;
  logic               first;
  logic [2:0]         cur_op;
  op_dec_t            dec;
  logic [WIDTH-1:0]   fold_c;
  logic [WIDTH-1:0]   new_acc;
  logic [WIDTH-1:0]   result;
  logic [CNT_W-1:0]   new_cnt;
  logic               new_err;
  logic               at_max;

  // The first beat of a packet uses the live op; later beats use the latched one.
  assign first  = (state_q == IDLE);
  assign cur_op = first ? op : op_q;
  assign dec    = op_decode(cur_op);
  assign at_max = (cnt_q == CNT_W'(MAX_LEN));

  bitwise_op_core #(.WIDTH(WIDTH)) u_core (
    .sel (dec.base),
    .a   (acc_q),
    .b   (in_data),
    .y_c (fold_c)
  );

  // Next accumulator/count/error and the finished result if this beat is the last.
  always_comb begin
    new_acc = first ? in_data : fold_c;
    new_cnt = first ? CNT_W'(1) : (at_max ? cnt_q : cnt_q + CNT_W'(1));
    new_err = first ? dec.rsvd : (err_q | at_max);
    if (dec.rsvd)     result = '0;
    else if (dec.inv) result = ~new_acc;
    else              result = new_acc;
  end

  // Next-state and output logic.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    op_d        = op_q;
    out_valid_d = out_valid;
    out_data_d  = out_data;
    out_count_d = out_count;
    out_err_d   = out_err;
    in_ready    = !rst && (state_q != DONE);
    accept      = in_valid && in_ready;

    unique case (state_q)
      IDLE, ACC: begin
        if (accept) begin
          acc_d = new_acc;
          cnt_d = new_cnt;
          err_d = new_err;
          op_d  = cur_op;
          if (in_last) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
            out_data_d  = result;
            out_count_d = new_cnt;
            out_err_d   = new_err;
          end else begin
            state_d = ACC;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          acc_d       = '0;
          cnt_d       = '0;
          err_d       = 1'b0;
          out_valid_d = 1'b0;
          out_data_d  = '0;
          out_count_d = '0;
          out_err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      op_q      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_count <= '0;
      out_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      op_q      <= op_d;
      out_valid <= out_valid_d;
      out_data  <= out_data_d;
      out_count <= out_count_d;
      out_err   <= out_err_d;
    end
  end

endmodule

// File: doc/bitwise_reduce_acc.md
Name: bitwise_reduce_acc

Overview:
Parametrised, registered successor to the team's two-input AND gate. It folds a packet of WIDTH-bit words into one result using a selectable bitwise operation (AND/OR/XOR and their inversions). Packets arrive and results leave over valid/ready handshakes. It sits between a word-stream producer and a consumer that needs per-packet masks or parity (e.g. flag aggregation).

Parameters:
WIDTH, 8, data word width in bits
MAX_LEN, 16, maximum beats per packet; longer packets are flagged
CNT_W, $clog2(MAX_LEN+1), width of the beat counter (derived, not overridden)

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
op  input  3  operation code, sampled on the first beat of a packet only
in_valid  input  1  upstream word valid
in_ready  output  1  block can accept a word
in_data  input  WIDTH  upstream word
in_last  input  1  marks the final word of the packet
out_valid  output  1  result valid
out_ready  input  1  downstream accepts the result
out_data  output  WIDTH  folded result
out_count  output  CNT_W  beats folded, saturating at MAX_LEN
out_err  output  1  packet overflowed MAX_LEN, or op was reserved

Behaviour:
- Op encoding: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6/7 reserved.
- Inverting ops fold with their base op (AND/OR/XOR). The inversion is applied once, to the final result, not per beat.
- A beat is accepted when in_valid && in_ready on a rising clk.
- FSM states: IDLE, ACC, DONE.
- IDLE:
  - in_ready=1.
  - On accept: latch op, acc=in_data, count=1, err=(op>5).
  - If in_last is high, go to DONE; otherwise go to ACC.
- ACC:
  - in_ready=1.
  - On accept: acc = acc (base op) in_data.
  - count increments while count<MAX_LEN. When count==MAX_LEN and another beat is accepted, count holds at MAX_LEN and err is set.
  - Beats past MAX_LEN are still folded into acc.
  - If in_last is high, go to DONE.
- DONE:
  - in_ready=0.
  - out_valid=1; out_data, out_count and out_err are stable and registered.
  - On out_valid && out_ready, go to IDLE. The new packet's first beat can be accepted in the following cycle, so there is a one-cycle bubble between packets.
- Latency: out_valid rises on the clock edge that accepts the in_last beat, so the result is visible in the next cycle.
- Reserved op: out_data=0 and out_err=1. Count still reflects the beats folded.
- Backpressure: while out_ready=0 in DONE, every output holds its value and in_valid is ignored.
- Reset, including mid-packet:
  - Any partial packet is discarded immediately.
  - state=IDLE, acc=0, count=0, err=0.
  - out_valid=0, out_data=0, out_count=0, out_err=0.
  - in_ready=0 while rst is high and 1 in the first cycle after release.
- out_data, out_count and out_err read 0 whenever out_valid=0.

Decomposition:
- Shared package:
  - op code constants: OP_AND..OP_XNOR, OP_RSVD_LO=6
  - FSM state enum: IDLE/ACC/DONE
  - a function mapping op to its base op and an invert flag
- One natural sub-module: bitwise_op_core, a combinational two-operand WIDTH-bit AND/OR/XOR selector. It is reused for the per-beat fold.
- Inversion, counter and FSM stay in the top level.

Test Plan:
1. WIDTH=8, op=0, beats 0xF0, 0x3C, 0xFF(last), out_ready=1 -> out_data=0x30, out_count=3, out_err=0; out_valid high for exactly one cycle.
2. op=5, single beat 0xA5 with in_last -> next cycle out_valid=1, out_data=0x5A, out_count=1. A second single-beat packet (op=2, 0x3C) presented with in_valid held high is accepted one cycle after the handshake -> out_data=0x3C.
3. op=1, beats 0x01, 0x80(last); out_ready held low 5 cycles with in_valid=1 -> in_ready=0 and out_data=0x81 stable throughout; completes on the 6th cycle, when out_ready rises.
4. MAX_LEN=4, op=2, six beats 0x01..0x06 -> out_data=0x07, out_count=4, out_err=1.
5. op=0, two beats accepted, then rst pulsed mid-packet -> all outputs 0 during reset. Then op=2, 0x0F, 0xFF(last) -> out_data=0xF0, out_count=2, out_err=0.
6. op=6, beats 0xAA, 0x55(last) -> out_data=0x00, out_count=2, out_err=1.
